hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/md_busy_timer.sv | 58 +++++
 rtl/hazard_controller.sv | 116 +++++++++++
 tb/tb_hazard_controller.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forwarding selects, multiply/divide FSM states,
// default unit latencies, and register-match helpers used by the hazard logic.
package pipeline_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef logic [0:0] md_state_t;
  localparam md_state_t MD_IDLE = 1'b0;
  localparam md_state_t MD_BUSY = 1'b1;

  localparam int unsigned DEFAULT_MULT_CYCLES = 4;
  localparam int unsigned DEFAULT_DIV_CYCLES  = 32;

  // Register 0 is hardwired to zero, so it can never carry a dependency.
  function automatic logic reg_hit(input logic [4:0] src, input logic src_used,
                                   input logic [4:0] dst, input logic dst_valid);
    return src_used && dst_valid && (src != 5'd0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] ex_src,
                                         input logic [4:0] mem_rd, input logic mem_wr,
                                         input logic [4:0] wb_rd, input logic wb_wr);
    if (reg_hit(ex_src, 1'b1, mem_rd, mem_wr)) return FWD_MEM;
    if (reg_hit(ex_src, 1'b1, wb_rd, wb_wr))   return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide occupancy timer: a two-state FSM that holds md_busy high for
// the selected unit latency, starting the cycle after a start is accepted.
module md_busy_timer
  import pipeline_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op,
  output logic md_busy
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] load_val;

  assign load_val = op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == MD_IDLE) begin
      if (start && (load_val != '0)) begin
        state_d = MD_BUSY;
        cnt_d   = load_val;
      end
    end else begin
      // The counter holds the number of busy cycles still to come, including this one.
      if (cnt_q <= CNT_W'(1)) begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign md_busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use and multiply/divide stalls, branch/jump
// flushes, operand forwarding selects and a stall-cycle counter.
// Optional feature macro: HAZARD_FORWARD_EN (EX operand forwarding from MEM/WB).
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic        id_jump,
  input  logic        ex_branch_taken,
  input  logic        id_md_start,
  input  logic        id_md_op,
  input  logic        id_md_read,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        md_busy,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [31:0] stall_count
);

  logic        load_use;
  logic        data_stall;
  logic        md_stall;
  logic        stall;
  logic        md_accept;
  logic [31:0] stall_count_q, stall_count_d;

  assign load_use = reg_hit(id_rs, id_use_rs, ex_rd, ex_mem_read) ||
                    reg_hit(id_rt, id_use_rt, ex_rd, ex_mem_read);

`ifdef HAZARD_FORWARD_EN
  logic unused_fwd_en;
  assign unused_fwd_en = ex_reg_write;

  assign data_stall = load_use;
  assign fwd_a      = fwd_sel(ex_rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  assign fwd_b      = fwd_sel(ex_rt, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
`else
  logic unused_fwd_dis;
  assign unused_fwd_dis = ^{ex_rs, ex_rt, wb_rd, wb_reg_write};

  // Without a bypass network, any in-flight writer of an ID source must drain first.
  assign data_stall = load_use ||
                      reg_hit(id_rs, id_use_rs, ex_rd, ex_reg_write) ||
                      reg_hit(id_rt, id_use_rt, ex_rd, ex_reg_write) ||
                      reg_hit(id_rs, id_use_rs, mem_rd, mem_reg_write) ||
                      reg_hit(id_rt, id_use_rt, mem_rd, mem_reg_write);
  assign fwd_a      = FWD_NONE;
  assign fwd_b      = FWD_NONE;
`endif

  assign md_stall  = md_busy && (id_md_start || id_md_read);
  assign stall     = data_stall || md_stall;
  assign md_accept = id_md_start && !md_busy && !stall && !ex_branch_taken;

  // A taken branch squashes ID, so it overrides any stall; a stalled jump is held.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (id_jump) begin
      if_id_flush = 1'b1;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_write) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (md_accept),
    .op      (id_md_op),
    .md_busy (md_busy)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: stalls, flushes, forwarding selects,
// multiply/divide busy timing and reset behaviour, with hand-computed expectations.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs, id_use_rt, ex_reg_write, ex_mem_read;
  logic        mem_reg_write, wb_reg_write, id_jump, ex_branch_taken;
  logic        id_md_start, id_md_op, id_md_read;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int busy_cycles;
  int stall_seen;

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .mem_rd          (mem_rd),
    .mem_reg_write   (mem_reg_write),
    .wb_rd           (wb_rd),
    .wb_reg_write    (wb_reg_write),
    .id_jump         (id_jump),
    .ex_branch_taken (ex_branch_taken),
    .id_md_start     (id_md_start),
    .id_md_op        (id_md_op),
    .id_md_read      (id_md_read),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .md_busy         (md_busy),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_count     (stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_rs = '0; ex_rt = '0; ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
    id_jump = 1'b0; ex_branch_taken = 1'b0;
    id_md_start = 1'b0; id_md_op = 1'b0; id_md_read = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) tick();
    settle();
    check("rst_pc_write", pc_write, 1);
    check("rst_if_id_write", if_id_write, 1);
    check("rst_if_id_flush", if_id_flush, 0);
    check("rst_id_ex_flush", id_ex_flush, 0);
    check("rst_fwd_a", fwd_a, 0);
    check("rst_fwd_b", fwd_b, 0);
    check("rst_md_busy", md_busy, 0);
    check("rst_stall_count", stall_count, 0);

    reset = 1'b0;
    tick();

    // Load-use on rs: one stall cycle.
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    settle();
    check("lu_pc_write", pc_write, 0);
    check("lu_if_id_write", if_id_write, 0);
    check("lu_id_ex_flush", id_ex_flush, 1);
    check("lu_if_id_flush", if_id_flush, 0);
    tick();
    clear_inputs();
    settle();
    check("lu_stall_count", stall_count, 1);
    check("lu_release", pc_write, 1);

    // Register 0 and unused sources never stall.
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    settle();
    check("r0_no_stall", pc_write, 1);
    ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b0;
    settle();
    check("unused_src_no_stall", pc_write, 1);
    clear_inputs();
    tick();

    // Load-use on rt, with jump held and branch override.
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_use_rt = 1'b1;
    settle();
    check("lu_rt_pc_write", pc_write, 0);
    id_jump = 1'b1;
    settle();
    check("jump_stall_if_id_flush", if_id_flush, 0);
    check("jump_stall_pc_write", pc_write, 0);
    ex_branch_taken = 1'b1;
    settle();
    check("br_ovr_pc_write", pc_write, 1);
    check("br_ovr_if_id_write", if_id_write, 1);
    check("br_ovr_if_id_flush", if_id_flush, 1);
    check("br_ovr_id_ex_flush", id_ex_flush, 1);
    ex_branch_taken = 1'b0; id_jump = 1'b0;
    tick();
    clear_inputs();
    settle();
    check("lu_rt_stall_count", stall_count, 2);

    // Unstalled jump flushes IF/ID only.
    id_jump = 1'b1;
    settle();
    check("jump_if_id_flush", if_id_flush, 1);
    check("jump_id_ex_flush", id_ex_flush, 0);
    check("jump_pc_write", pc_write, 1);
    check("jump_if_id_write", if_id_write, 1);
    clear_inputs();
    tick();

    // Forwarding selects, or extra stalls when forwarding is compiled out.
    ex_rs = 5'd9; ex_rt = 5'd9; mem_reg_write = 1'b1; mem_rd = 5'd9;
    wb_reg_write = 1'b1; wb_rd = 5'd9;
    settle();
`ifdef HAZARD_FORWARD_EN
    check("fwd_a_mem", fwd_a, 2'b10);
    check("fwd_b_mem", fwd_b, 2'b10);
    mem_reg_write = 1'b0;
    settle();
    check("fwd_a_wb", fwd_a, 2'b01);
    ex_rs = 5'd0;
    settle();
    check("fwd_a_r0", fwd_a, 2'b00);
    check("fwd_b_wb", fwd_b, 2'b01);
    mem_reg_write = 1'b1; id_rs = 5'd9; id_use_rs = 1'b1;
    settle();
    check("fwd_no_stall", pc_write, 1);
`else
    check("nofwd_a", fwd_a, 2'b00);
    check("nofwd_b", fwd_b, 2'b00);
    id_rs = 5'd9; id_use_rs = 1'b1;
    settle();
    check("nofwd_mem_stall", pc_write, 0);
    mem_reg_write = 1'b0;
    settle();
    check("nofwd_wb_no_stall", pc_write, 1);
    ex_reg_write = 1'b1; ex_rd = 5'd9;
    settle();
    check("nofwd_ex_stall", pc_write, 0);
    ex_rd = 5'd0; id_rs = 5'd0;
    settle();
    check("nofwd_r0_no_stall", pc_write, 1);
`endif
    clear_inputs();
    tick();
    check("fwd_stall_count", stall_count, 2);

    // Divide followed by mfhi/mflo: 32 busy cycles, all stalled.
    id_md_start = 1'b1; id_md_op = 1'b1;
    settle();
    check("div_start_pc_write", pc_write, 1);
    check("div_start_busy", md_busy, 0);
    tick();
    id_md_start = 1'b0; id_md_read = 1'b1;
    settle();
    busy_cycles = 0;
    stall_seen  = 0;
    for (int i = 0; i < 40 && md_busy; i++) begin
      busy_cycles++;
      if (!pc_write) stall_seen++;
      tick();
    end
    check("div_busy_cycles", busy_cycles, 32);
    check("div_stall_cycles", stall_seen, 32);
    check("div_release_pc_write", pc_write, 1);
    check("div_stall_count", stall_count, 34);
    clear_inputs();
    tick();

    // Multiply with a taken branch while md_stall is active.
    id_md_start = 1'b1; id_md_op = 1'b0;
    tick();
    check("mult_busy", md_busy, 1);
    ex_branch_taken = 1'b1;
    settle();
    check("mdbr_pc_write", pc_write, 1);
    check("mdbr_if_id_write", if_id_write, 1);
    check("mdbr_if_id_flush", if_id_flush, 1);
    check("mdbr_id_ex_flush", id_ex_flush, 1);
    busy_cycles = 1;
    tick();
    clear_inputs();
    settle();
    for (int i = 0; i < 10 && md_busy; i++) begin
      busy_cycles++;
      tick();
    end
    check("mult_busy_cycles", busy_cycles, 4);
    tick();
    check("mult_no_restart", md_busy, 0);

    // Stalled or branched start while idle is not accepted.
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    id_md_start = 1'b1; ex_branch_taken = 1'b1;
    settle();
    check("idle_br_pc_write", pc_write, 1);
    tick();
    clear_inputs();
    settle();
    check("idle_br_no_accept", md_busy, 0);
    check("idle_br_stall_count", stall_count, 34);
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    id_md_start = 1'b1;
    settle();
    check("idle_stall_pc_write", pc_write, 0);
    tick();
    clear_inputs();
    settle();
    check("idle_stall_no_accept", md_busy, 0);
    check("idle_stall_count", stall_count, 35);

    // Reset in the tenth busy cycle of a divide.
    id_md_start = 1'b1; id_md_op = 1'b1;
    tick();
    id_md_start = 1'b0; id_md_read = 1'b1;
    repeat (9) tick();
    check("rdiv_busy_before", md_busy, 1);
    reset = 1'b1;
    tick();
    check("rdiv_md_busy", md_busy, 0);
    check("rdiv_stall_count", stall_count, 0);
    reset = 1'b0;
    clear_inputs();
    tick();
    check("rdiv_stays_idle", md_busy, 0);
    check("rdiv_count_held", stall_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
